pwm_multi_gen: RTL and testbench

- Parametrised, multi-channel successor to the single-channel PWM generator.
- One shared period counter drives CHANNELS outputs. Each channel has its own duty, enable and polarity.
- Period is programmed directly in clock ticks, so there is no runtime divider.
- Every configuration write is double-buffered and takes effect only at a period boundary, so no glitched or partial PWM cycles appear. Sits between the control/register logic and motor, LED or servo pins.

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/pwm_compare_ch.sv | 39 +++
 rtl/pwm_multi_gen.sv | 110 +++++++++++
 tb/tb_pwm_multi_gen.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_CHANNELS = 4;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Ceiling log2, never below 1 so a single channel still gets a 1-bit index.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res++;
    end
    if (res < 1) begin
      res = 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM channel: double-buffered duty threshold, comparator and output flop.
module pwm_compare_ch
  import pwm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             xfer,
  input  logic [CNT_W-1:0] cnt,
  input  logic             en,
  input  logic             inv,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_shadow;
  logic [CNT_W-1:0] duty_active;

  // The shadow is read before this edge's write lands, so a write on a
  // boundary cycle waits for the following boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_shadow <= '0;
      duty_active <= '0;
      pwm         <= 1'b0;
    end else begin
      if (wr) begin
        duty_shadow <= duty_in;
      end
      if (xfer) begin
        duty_active <= duty_shadow;
      end
      pwm <= en ? ((cnt < duty_active) ^ inv) : inv;
    end
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared edge/center period counter, period
// shadow and boundary sync, with per-channel compare units.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CH_W     = clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CNT_W-1:0]    period_in,
  input  logic                period_wr,
  input  logic                center_in,
  input  logic                duty_wr,
  input  logic [CH_W-1:0]     duty_ch,
  input  logic [CNT_W-1:0]    duty_in,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic [CHANNELS-1:0] ch_inv,
  output logic [CHANNELS-1:0] pwm,
  output logic                sync,
  output logic [CNT_W-1:0]    cnt,
  output logic                pending
);

  logic [CNT_W-1:0]    period_shadow;
  logic [CNT_W-1:0]    period_active;
  mode_e               center_shadow;
  mode_e               center_active;
  dir_e                dir;
  dir_e                dir_next;
  logic [CNT_W-1:0]    cnt_next;
  logic                boundary;
  logic [CHANNELS-1:0] duty_sel;
  logic                duty_accept;

  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    dir_next = dir;
    if (center_active == MODE_CENTER) begin
      if (dir == DIR_UP) begin
        if (cnt >= period_active) begin
          cnt_next = (period_active == '0) ? '0 : period_active - CNT_W'(1);
          dir_next = DIR_DOWN;
        end
      end else begin
        cnt_next = (cnt <= CNT_W'(1)) ? '0 : cnt - CNT_W'(1);
      end
    end else if (cnt >= period_active) begin
      cnt_next = '0;
    end
    boundary = (cnt_next == '0);
    // Every period, including a mode switch, starts counting up from 0.
    if (boundary) begin
      dir_next = DIR_UP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      dir           <= DIR_UP;
      period_shadow <= '0;
      period_active <= '0;
      center_shadow <= MODE_EDGE;
      center_active <= MODE_EDGE;
      sync          <= 1'b0;
      pending       <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      dir  <= dir_next;
      sync <= boundary;
      if (period_wr) begin
        period_shadow <= period_in;
        center_shadow <= mode_e'(center_in);
      end
      if (boundary) begin
        period_active <= period_shadow;
        center_active <= center_shadow;
      end
      if (period_wr || duty_accept) begin
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign duty_sel[gi] = duty_wr && (duty_ch == CH_W'(gi));

    pwm_compare_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (duty_sel[gi]),
      .duty_in (duty_in),
      .xfer    (boundary),
      .cnt     (cnt),
      .en      (ch_en[gi]),
      .inv     (ch_inv[gi]),
      .pwm     (pwm[gi])
    );
  end

  // Out-of-range channel indices match no channel and are dropped.
  assign duty_accept = |duty_sel;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: per-cycle scoreboard from a phase-based
// reference model plus directed checks from the test plan.
module tb_pwm_multi_gen;

  localparam int CHANNELS = 4;
  localparam int CNT_W    = 16;
  localparam int CH_W     = 3;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [CNT_W-1:0]    period_in;
  logic                period_wr;
  logic                center_in;
  logic                duty_wr;
  logic [CH_W-1:0]     duty_ch;
  logic [CNT_W-1:0]    duty_in;
  logic [CHANNELS-1:0] ch_en;
  logic [CHANNELS-1:0] ch_inv;
  logic [CHANNELS-1:0] pwm;
  logic                sync;
  logic [CNT_W-1:0]    cnt;
  logic                pending;

  always #5 clk = ~clk;

  pwm_multi_gen #(
    .CHANNELS(CHANNELS),
    .CNT_W   (CNT_W),
    .CH_W    (CH_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .period_in (period_in),
    .period_wr (period_wr),
    .center_in (center_in),
    .duty_wr   (duty_wr),
    .duty_ch   (duty_ch),
    .duty_in   (duty_in),
    .ch_en     (ch_en),
    .ch_inv    (ch_inv),
    .pwm       (pwm),
    .sync      (sync),
    .cnt       (cnt),
    .pending   (pending)
  );

  typedef struct {
    logic [CHANNELS-1:0] pwm;
    logic                sync;
    logic [CNT_W-1:0]    cnt;
    logic                pending;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int hi_ch[CHANNELS];
  int sync_cnt;

  // Reference model: position k inside a period of length len; cnt derived from k.
  int m_k, m_p, m_c, m_pend, sh_p, sh_c;
  int m_d[CHANNELS];
  int sh_d[CHANNELS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int len_of(input int p, input int c);
    if (c != 0) return (p == 0) ? 1 : 2 * p;
    return p + 1;
  endfunction

  function automatic int cnt_of(input int k, input int p, input int c);
    if (c != 0 && k > p) return 2 * p - k;
    return k;
  endfunction

  task automatic model_reset();
    m_k = 0; m_p = 0; m_c = 0; m_pend = 0; sh_p = 0; sh_c = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      m_d[i] = 0;
      sh_d[i] = 0;
    end
  endtask

  task automatic clear_counts();
    sync_cnt = 0;
    for (int i = 0; i < CHANNELS; i++) hi_ch[i] = 0;
  endtask

  task automatic step();
    exp_t e;
    exp_t o;
    int cur, kn;
    bit bnd, acc, dacc;
    cur = cnt_of(m_k, m_p, m_c);
    for (int i = 0; i < CHANNELS; i++)
      e.pwm[i] = ch_en[i] ? ((cur < m_d[i]) ^ ch_inv[i]) : ch_inv[i];
    kn   = (m_k + 1) % len_of(m_p, m_c);
    bnd  = (kn == 0);
    dacc = duty_wr && (int'(duty_ch) < CHANNELS);
    acc  = period_wr || dacc;
    if (bnd) begin
      m_p = sh_p;
      m_c = sh_c;
      for (int i = 0; i < CHANNELS; i++) m_d[i] = sh_d[i];
    end
    if (period_wr) begin
      sh_p = int'(period_in);
      sh_c = int'(center_in);
    end
    if (dacc) sh_d[duty_ch] = int'(duty_in);
    if (acc) m_pend = 1;
    else if (bnd) m_pend = 0;
    m_k = kn;
    e.sync    = bnd;
    e.cnt     = CNT_W'(cnt_of(m_k, m_p, m_c));
    e.pending = m_pend[0];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    period_wr = 1'b0;
    duty_wr   = 1'b0;
    o = sb_q.pop_front();
    check("pwm", 32'(pwm), 32'(o.pwm));
    check("sync", 32'(sync), 32'(o.sync));
    check("cnt", 32'(cnt), 32'(o.cnt));
    check("pending", 32'(pending), 32'(o.pending));
    for (int i = 0; i < CHANNELS; i++) if (pwm[i]) hi_ch[i]++;
    if (sync) sync_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic write_period(input int p, input bit c);
    period_in = CNT_W'(p);
    center_in = c;
    period_wr = 1'b1;
    $display("period write P=%0d center=%0d", p, c);
    step();
  endtask

  task automatic write_duty(input int ch, input int d);
    duty_ch = CH_W'(ch);
    duty_in = CNT_W'(d);
    duty_wr = 1'b1;
    $display("duty write ch=%0d D=%0d", ch, d);
    step();
  endtask

  task automatic wait_sync(input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (sync) return;
    end
    check("sync_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cnt(input int v, input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (int'(cnt) == v) return;
    end
    check("cnt_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int seq[8];
    seq = '{1, 2, 3, 4, 3, 2, 1, 0};
    reset_n = 1'b0; period_in = '0; period_wr = 1'b0; center_in = 1'b0;
    duty_wr = 1'b0; duty_ch = '0; duty_in = '0; ch_en = '0; ch_inv = '0;
    model_reset();
    clear_counts();
    @(posedge clk);
    #1;
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_sync", 32'(sync), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    reset_n = 1'b1;

    // Edge mode, 50% duty
    ch_en = 4'b0001;
    write_period(9, 1'b0);
    write_duty(0, 5);
    wait_sync(20);
    clear_counts();
    run(20);
    check("edge_hi", 32'(hi_ch[0]), 32'd10);
    check("edge_sync", 32'(sync_cnt), 32'd2);

    // Double buffering mid-period
    wait_cnt(3, 20);
    write_duty(0, 8);
    check("pend_set", 32'(pending), 32'd1);
    wait_sync(20);
    check("pend_clear", 32'(pending), 32'd0);
    clear_counts();
    run(10);
    check("dbuf_hi", 32'(hi_ch[0]), 32'd8);

    // Duty extremes, disabled inverted channel, out-of-range channel index
    ch_en  = 4'b0111;
    ch_inv = 4'b1000;
    write_duty(1, 0);
    write_duty(2, 10);
    wait_sync(20);
    write_duty(5, 7);
    check("bad_ch_pend", 32'(pending), 32'd0);
    clear_counts();
    run(10);
    check("d0_hi", 32'(hi_ch[1]), 32'd0);
    check("dfull_hi", 32'(hi_ch[2]), 32'd10);
    check("inv_off_hi", 32'(hi_ch[3]), 32'd10);

    // Center mode
    ch_en  = 4'b0001;
    ch_inv = 4'b0000;
    write_period(4, 1'b1);
    write_duty(0, 2);
    wait_sync(20);
    wait_sync(20);
    for (int i = 0; i < 8; i++) begin
      step();
      check("ctr_seq", 32'(cnt), 32'(seq[i]));
    end
    clear_counts();
    run(16);
    check("ctr_hi", 32'(hi_ch[0]), 32'd6);
    check("ctr_sync", 32'(sync_cnt), 32'd2);

    // P=0 then P=3
    write_period(0, 1'b0);
    wait_sync(20);
    wait_sync(20);
    clear_counts();
    run(6);
    check("p0_sync", 32'(sync_cnt), 32'd6);
    check("p0_cnt", 32'(cnt), 32'd0);
    write_period(3, 1'b0);
    step();
    check("p3_xfer", 32'(sync), 32'd1);
    clear_counts();
    run(8);
    check("p3_sync", 32'(sync_cnt), 32'd2);

    // Random writes, including simultaneous and boundary-coincident strobes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        ch_en  = CHANNELS'($urandom);
        ch_inv = CHANNELS'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        period_in = CNT_W'($urandom_range(0, 12));
        center_in = 1'($urandom_range(0, 1));
        period_wr = 1'b1;
        $display("period write P=%0d center=%0d", period_in, center_in);
      end
      if ($urandom_range(0, 4) == 0) begin
        duty_ch = CH_W'($urandom_range(0, 7));
        duty_in = CNT_W'($urandom_range(0, 14));
        duty_wr = 1'b1;
        $display("duty write ch=%0d D=%0d", duty_ch, duty_in);
      end
      step();
    end

    // Asynchronous reset mid-period
    ch_en  = 4'b0001;
    ch_inv = 4'b0010;
    write_period(9, 1'b0);
    wait_sync(40);
    write_duty(0, 5);
    wait_sync(20);
    wait_sync(20);
    wait_cnt(6, 20);
    period_in = CNT_W'(2);
    period_wr = 1'b1;
    duty_ch   = '0;
    duty_in   = CNT_W'(9);
    duty_wr   = 1'b1;
    $display("period write P=2 center=0 and duty write ch=0 D=9 before reset");
    step();
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_cnt", 32'(cnt), 32'd0);
    check("arst_pwm", 32'(pwm), 32'd0);
    check("arst_sync", 32'(sync), 32'd0);
    check("arst_pending", 32'(pending), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    step();
    clear_counts();
    run(5);
    check("arst_lost_sync", 32'(sync_cnt), 32'd5);
    check("arst_lost_hi", 32'(hi_ch[0]), 32'd0);
    check("arst_inv_hi", 32'(hi_ch[1]), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
